// File: rtl/spectrum_magnitude_pipe.sv
// Alpha-max-plus-beta-min magnitude estimator with per-bin peak-hold/decay feeding display RAM.
// Latency: 5 cycles from we to delay_we, one sample per cycle throughput.
// Backpressure: none; every stage advances every cycle and the output cannot be stalled.
//
// Ports:
//   clk, rst         sole clock (rising edge), asynchronous active-low reset
//   we, addr         input sample valid and its bin index
//   fft_r, fft_i     signed real/imag FFT parts
//   mode, hold_en    coefficient select and peak-hold enable, travel with the sample
//   delay_we         output valid / display RAM write enable
//   delay_addr, data bin index aligned with data; data = TOP - displayed level
module spectrum_magnitude_pipe #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 18,
  parameter int OUT_WIDTH   = 9,
  parameter int TOP         = 480,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] fft_r,
  input  logic [DATA_WIDTH-1:0] fft_i,
  input  logic [1:0]            mode,
  input  logic                  hold_en,
  output logic                  delay_we,
  output logic [ADDR_WIDTH-1:0] delay_addr,
  output logic [OUT_WIDTH-1:0]  data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [OUT_WIDTH-1:0] TOP_V = OUT_WIDTH'(TOP);
  localparam logic [DATA_WIDTH-1:0] ONE_D = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [OUT_WIDTH-1:0]  ONE_O = {{(OUT_WIDTH-1){1'b0}}, 1'b1};

  // pN_* registers hold the result of stage N.
  logic                  p1_vld, p2_vld, p3_vld, p4_vld;
  logic [ADDR_WIDTH-1:0] p1_addr, p2_addr, p3_addr, p4_addr;
  logic [1:0]            p1_mode, p2_mode;
  logic                  p1_hold, p2_hold, p3_hold, p4_hold;
  logic [DATA_WIDTH-1:0] p1_r, p1_i;
  logic [DATA_WIDTH-1:0] p2_mx, p2_mn;
  logic [OUT_WIDTH:0]    p3_mag_hi;  // mag[DATA_WIDTH : DATA_WIDTH-OUT_WIDTH]
  logic [OUT_WIDTH-1:0]  p4_level, p4_held;

  logic [OUT_WIDTH-1:0]  held_q [DEPTH];

  // S1: absolute value. Two's-complement negate of the most negative input
  // yields exactly 2^(DATA_WIDTH-1) as unsigned, so no saturation is needed.
  logic [DATA_WIDTH-1:0] r_abs, i_abs;
  always_comb begin
    r_abs = fft_r[DATA_WIDTH-1] ? ((~fft_r) + ONE_D) : fft_r;
    i_abs = fft_i[DATA_WIDTH-1] ? ((~fft_i) + ONE_D) : fft_i;
  end

  // S2: max/min, ties resolve to mx = |r|.
  logic [DATA_WIDTH-1:0] mx_nxt, mn_nxt;
  always_comb begin
    mx_nxt = p1_r;
    mn_nxt = p1_i;
    if (p1_i > p1_r) begin
      mx_nxt = p1_i;
      mn_nxt = p1_r;
    end
  end

  // S3: coefficient modes on a one-bit-wider magnitude; only the bits used
  // for scaling plus the overflow bit are registered.
  logic [DATA_WIDTH:0] mxw, mnw, sum0, mag;
  always_comb begin
    mxw  = {1'b0, p2_mx};
    mnw  = {1'b0, p2_mn};
    sum0 = mxw + (mnw >> 1);
    case (p2_mode)
      2'd0:    mag = sum0 - (sum0 >> 4);
      2'd1:    mag = mxw + (mnw >> 2);
      2'd2:    mag = mxw - (mxw >> 4) + (mnw >> 1) - (mnw >> 5);
      default: mag = mxw;
    endcase
  end

  // S5 combinational result, needed by S4 for same-bin forwarding.
  logic [OUT_WIDTH-1:0] dec_step, dec, out_val;
  always_comb begin
    dec_step = p4_held >> DECAY_SHIFT;
    if (dec_step == '0) dec_step = ONE_O;
    dec = (p4_held != '0) ? (p4_held - dec_step) : '0;
    if (!p4_hold)           out_val = p4_level;
    else if (p4_level > dec) out_val = p4_level;
    else                    out_val = dec;
  end

  // S4: scale, saturate, clamp to TOP, read held value. The sample in S5 is
  // writing its result this same edge, so a matching bin takes that value.
  logic [OUT_WIDTH-1:0] scaled, level, held_rd;
  always_comb begin
    scaled  = p3_mag_hi[OUT_WIDTH] ? '1 : p3_mag_hi[OUT_WIDTH-1:0];
    level   = (scaled > TOP_V) ? TOP_V : scaled;
    held_rd = (p4_vld && (p4_addr == p3_addr)) ? out_val : held_q[p3_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_vld <= 1'b0; p2_vld <= 1'b0; p3_vld <= 1'b0; p4_vld <= 1'b0;
      p1_addr <= '0; p2_addr <= '0; p3_addr <= '0; p4_addr <= '0;
      p1_mode <= '0; p2_mode <= '0;
      p1_hold <= 1'b0; p2_hold <= 1'b0; p3_hold <= 1'b0; p4_hold <= 1'b0;
      p1_r <= '0; p1_i <= '0;
      p2_mx <= '0; p2_mn <= '0;
      p3_mag_hi <= '0;
      p4_level <= '0; p4_held <= '0;
      delay_we <= 1'b0;
      delay_addr <= '0;
      data <= TOP_V;
      for (int k = 0; k < DEPTH; k++) held_q[k] <= '0;
    end else begin
      p1_vld <= we;     p1_addr <= addr;    p1_mode <= mode;    p1_hold <= hold_en;
      p1_r   <= r_abs;  p1_i    <= i_abs;

      p2_vld <= p1_vld; p2_addr <= p1_addr; p2_mode <= p1_mode; p2_hold <= p1_hold;
      p2_mx  <= mx_nxt; p2_mn   <= mn_nxt;

      p3_vld <= p2_vld; p3_addr <= p2_addr; p3_hold <= p2_hold;
      p3_mag_hi <= (OUT_WIDTH+1)'(mag >> (DATA_WIDTH - OUT_WIDTH));

      p4_vld <= p3_vld; p4_addr <= p3_addr; p4_hold <= p3_hold;
      p4_level <= level; p4_held <= held_rd;

      // Hold array is refreshed on every valid sample, hold_en or not.
      delay_we <= p4_vld;
      if (p4_vld) begin
        held_q[p4_addr] <= out_val;
        data            <= TOP_V - out_val;
        delay_addr      <= p4_addr;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_magnitude_pipe.sv
module tb_spectrum_magnitude_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [5:0]  addr;
  logic [17:0] fft_r, fft_i;
  logic [1:0]  mode;
  logic        hold_en;
  logic        delay_we;
  logic [5:0]  delay_addr;
  logic [8:0]  data;

  spectrum_magnitude_pipe dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .fft_r(fft_r), .fft_i(fft_i),
    .mode(mode), .hold_en(hold_en), .delay_we(delay_we), .delay_addr(delay_addr),
    .data(data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { bit v; int a; int d; } exp_t;
  exp_t pe[$];
  int   held_m [64];
  int   exp_we, exp_addr, exp_data;
  int   seen[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: magnitude/level/peak-hold computed directly from the rules.
  function automatic int ref_out(int r, int i, int md, bit he, int held);
    int ar, ai, mx, mn, s, mag, sc, lvl, dec, st;
    ar = (r < 0) ? -r : r;
    ai = (i < 0) ? -i : i;
    mx = (ar >= ai) ? ar : ai;
    mn = (ar >= ai) ? ai : ar;
    case (md)
      0: begin s = mx + mn / 2; mag = s - s / 16; end
      1: mag = mx + mn / 4;
      2: mag = mx - mx / 16 + mn / 2 - mn / 32;
      default: mag = mx;
    endcase
    sc  = (mag >= 262144) ? 511 : mag / 512;
    lvl = (sc > 480) ? 480 : sc;
    if (!he) return lvl;
    if (held > 0) begin
      st  = held / 8;
      if (st < 1) st = 1;
      dec = held - st;
    end else dec = 0;
    return (lvl > dec) ? lvl : dec;
  endfunction

  task automatic model_clear();
    pe.delete();
    for (int k = 0; k < 64; k++) held_m[k] = 0;
    exp_we = 0; exp_addr = 0; exp_data = 480;
  endtask

  task automatic model_push(input bit v, input int r, input int i, input int md,
                            input bit he, input int a);
    exp_t e, o;
    e.v = v; e.a = a; e.d = 0;
    if (v) begin
      int ov;
      ov = ref_out(r, i, md, he, held_m[a]);
      held_m[a] = ov;
      e.d = 480 - ov;
    end
    pe.push_back(e);
    exp_we = 0;
    if (pe.size() == 5) begin
      o = pe.pop_front();
      exp_we = o.v;
      if (o.v) begin exp_addr = o.a; exp_data = o.d; end
    end
  endtask

  task automatic step(input bit v, input int r, input int i, input int md,
                      input bit he, input int a);
    we = v; fft_r = 18'(r); fft_i = 18'(i); mode = 2'(md); hold_en = he; addr = 6'(a);
    @(posedge clk);
    if (rst) model_push(v, r, i, md, he, a);
    else     model_clear();
    #1;
    chk("delay_we", delay_we, exp_we);
    chk("delay_addr", delay_addr, exp_addr);
    chk("data", data, exp_data);
    if (delay_we === 1'b1) seen.push_back(int'(data));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rnd18();
    if ($urandom_range(0, 15) == 0) return ($urandom_range(0, 1) != 0) ? -131072 : 131071;
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  initial begin
    int lat;
    bit mono;
    rst = 1'b0; we = 0; addr = 0; fft_r = 0; fft_i = 0; mode = 0; hold_en = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", delay_we, 0);
    chk("reset_data", data, 480);
    chk("reset_addr", delay_addr, 0);
    rst = 1'b1;

    // Stream with we pulsing, then asynchronous reset mid-stream.
    for (int k = 0; k < 8; k++) step(k != 3, rnd18(), rnd18(), k % 4, k[0], k + 10);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_we", delay_we, 0);
    chk("async_rst_data", data, 480);
    chk("async_rst_addr", delay_addr, 0);
    step(1, 1000, 2000, 0, 1, 4);
    step(1, 3000, 2000, 1, 0, 5);
    rst = 1'b1;
    idle(3);

    // First output after reset appears 5 cycles after the first we.
    step(1, 65536, 0, 0, 0, 9);
    lat = 0;
    while (delay_we !== 1'b1 && lat < 10) begin step(0, 0, 0, 0, 0, 0); lat++; end
    chk("latency", lat, 4);

    // Coefficient modes, single-tone input.
    step(1, 65536, 0, 0, 0, 3);  idle(4); chk("mode0_pos", data, 360);
    step(1, 65536, 0, 3, 0, 3);  idle(4); chk("mode3_pos", data, 352);
    step(1, -65536, 0, 0, 0, 3); idle(4); chk("mode0_neg", data, 360);
    step(1, -65536, 0, 3, 0, 3); idle(4); chk("mode3_neg", data, 352);
    // Mixed inputs.
    step(1, 131071, 131071, 0, 0, 3); idle(4); chk("mixed_mode0", data, 121);
    step(1, 131071, 131071, 1, 0, 3); idle(4); chk("mixed_mode1", data, 161);
    step(1, 131071, 131071, 2, 0, 3); idle(4);
    chk("mixed_mode2", data, 480 - ref_out(131071, 131071, 2, 0, 0));

    // Peak-hold decay on bin 5.
    seen.delete();
    step(1, 65536, 0, 0, 1, 5);
    for (int k = 0; k < 45; k++) step(1, 0, 0, 0, 1, 5);
    idle(4);
    chk("decay_count", seen.size(), 46);
    chk("decay_0", seen[0], 360);
    chk("decay_1", seen[1], 375);
    chk("decay_2", seen[2], 388);
    mono = 1;
    for (int k = 1; k < seen.size(); k++) if (seen[k] < seen[k-1]) mono = 0;
    chk("decay_monotonic", mono, 1);
    chk("decay_final", seen[seen.size()-1], 480);

    // Interleaved bins then same-bin burst.
    step(1, 100000, 5000, 0, 1, 5);
    step(1, 60000, 90000, 1, 1, 6);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 0, 1, 5 + (k % 2));
    step(1, 120000, -40000, 2, 1, 7);
    step(1, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 1, 7);
    idle(4);

    // Random traffic.
    for (int k = 0; k < 10000; k++)
      step($urandom_range(0, 3) != 0, rnd18(), rnd18(), $urandom_range(0, 3),
           $urandom_range(0, 1) != 0, $urandom_range(0, 63));
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
